// File: rtl/frame_length_pairer.sv
// Pairs a frame-length token with its AXI4-Stream frame and forwards the frame with the length on tuser.
// Define FRAME_LENGTH_PAIRER_CHECK_EN to build the L1 length recheck (length_error / error_count).
module frame_length_pairer #(
  parameter int C_AXIS_TDATA_WIDTH      = 8,
  parameter int C_AXIS_TKEEP_WIDTH      = C_AXIS_TDATA_WIDTH / 8,
  parameter int FRAME_LENGTH_WIDTH      = 16,
  parameter int ENABLE_TIMESTAMP_FOOTER = 1,
  parameter int TIMESTAMP_WIDTH         = 72,
  parameter int L1_LENGTH_OFFSET        = 24,
  parameter int ERROR_COUNT_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
  input  logic                          s_axis_frame_length_tvalid,
  output logic                          s_axis_frame_length_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [FRAME_LENGTH_WIDTH-1:0] m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          length_error,
  output logic [ERROR_COUNT_WIDTH-1:0]  error_count
);

  typedef enum logic {IDLE, FORWARD} state_t;

  state_t                        state;
  logic [FRAME_LENGTH_WIDTH-1:0] length_reg;
  logic                          token_hs;
  logic                          beat_hs;

  // Handshake outputs are gated by rstn so they drop the instant reset asserts.
  assign s_axis_frame_length_tready = rstn && (state == IDLE);
  assign s_axis_tready              = rstn && (state == FORWARD) && m_axis_tready;
  assign m_axis_tvalid              = rstn && (state == FORWARD) && s_axis_tvalid;
  assign m_axis_tdata               = s_axis_tdata;
  assign m_axis_tkeep               = s_axis_tkeep;
  assign m_axis_tlast               = s_axis_tlast;
  assign m_axis_tuser               = length_reg;

  assign token_hs = s_axis_frame_length_tvalid && s_axis_frame_length_tready;
  assign beat_hs  = s_axis_tvalid && s_axis_tready;

`ifdef FRAME_LENGTH_PAIRER_CHECK_EN
  localparam logic [FRAME_LENGTH_WIDTH-1:0] OFFSET   = FRAME_LENGTH_WIDTH'(L1_LENGTH_OFFSET);
  localparam logic [FRAME_LENGTH_WIDTH-1:0] TS_BYTES =
    (ENABLE_TIMESTAMP_FOOTER != 0) ? FRAME_LENGTH_WIDTH'(TIMESTAMP_WIDTH / 8) : '0;
  localparam logic [FRAME_LENGTH_WIDTH-1:0] BEAT_BYTES = FRAME_LENGTH_WIDTH'(C_AXIS_TKEEP_WIDTH);

  logic [FRAME_LENGTH_WIDTH-1:0] byte_counter;
  logic [FRAME_LENGTH_WIDTH-1:0] num_bytes;
  logic [FRAME_LENGTH_WIDTH-1:0] computed;

  // Byte count of a beat is the highest enabled lane + 1, not a popcount.
  always_comb begin
    num_bytes = '0;
    for (int unsigned i = 0; i < C_AXIS_TKEEP_WIDTH; i++) begin
      if (s_axis_tkeep[i]) num_bytes = FRAME_LENGTH_WIDTH'(i + 1);
    end
  end

  assign computed = byte_counter + num_bytes - TS_BYTES;
`else
  assign length_error = 1'b0;
  assign error_count  = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      length_reg <= '0;
`ifdef FRAME_LENGTH_PAIRER_CHECK_EN
      byte_counter <= OFFSET;
      length_error <= 1'b0;
      error_count  <= '0;
`endif
    end else begin
`ifdef FRAME_LENGTH_PAIRER_CHECK_EN
      length_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (token_hs) begin
            length_reg <= s_axis_frame_length_tdata;
`ifdef FRAME_LENGTH_PAIRER_CHECK_EN
            byte_counter <= OFFSET;
`endif
            state <= FORWARD;
          end
        end
        FORWARD: begin
          if (beat_hs) begin
            if (s_axis_tlast) begin
              state <= IDLE;
`ifdef FRAME_LENGTH_PAIRER_CHECK_EN
              if (computed != length_reg) begin
                length_error <= 1'b1;
                if (error_count != '1) error_count <= error_count + ERROR_COUNT_WIDTH'(1);
              end
`endif
            end else begin
`ifdef FRAME_LENGTH_PAIRER_CHECK_EN
              byte_counter <= byte_counter + BEAT_BYTES;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_length_pairer.sv
// Self-checking bench for frame_length_pairer: vector table, directed corner cases, random frames vs. a frame-level model.
module tb_frame_length_pairer;

`ifdef FRAME_LENGTH_PAIRER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int LW = 16;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [LW-1:0] tok_data = '0;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic [LW-1:0] m_user;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          length_error;
  logic [EW-1:0] error_count;

  frame_length_pairer #(
    .C_AXIS_TDATA_WIDTH(DW),
    .C_AXIS_TKEEP_WIDTH(KW),
    .FRAME_LENGTH_WIDTH(LW),
    .ENABLE_TIMESTAMP_FOOTER(1),
    .TIMESTAMP_WIDTH(72),
    .L1_LENGTH_OFFSET(24),
    .ERROR_COUNT_WIDTH(EW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_axis_frame_length_tdata(tok_data),
    .s_axis_frame_length_tvalid(tok_valid),
    .s_axis_frame_length_tready(tok_ready),
    .s_axis_tdata(s_data),
    .s_axis_tkeep(s_keep),
    .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .s_axis_tlast(s_last),
    .m_axis_tdata(m_data),
    .m_axis_tkeep(m_keep),
    .m_axis_tuser(m_user),
    .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready),
    .m_axis_tlast(m_last),
    .length_error(length_error),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    beat_t         b;
    logic [LW-1:0] user;
  } exp_t;

  typedef struct {
    int token;
    int nbeats;
    int last_len;
    int mode;
    bit err;
  } vec_t;

  logic [LW-1:0] tok_q[$];
  beat_t         beat_q[$];
  exp_t          exp_q[$];
  bit            exp_err_q[$];

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  frames_done = 0;
  int  tok_hs_cyc = 0;
  int  frame_start_cyc = 0;
  int  ready_mode = 0;
  bit  tok_hold = 1'b0;
  bit  tok_hs = 1'b0;
  bit  beat_hs = 1'b0;
  bit  first_of_frame = 1'b1;
  bit  err_due = 1'b0;
  bit  err_exp = 1'b0;
  int  cnt_exp = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: L1 length = payload bytes - footer + offset, with full non-last beats.
  function automatic logic [LW-1:0] l1_len(input int nbeats, input int last_len);
    return LW'(KW * (nbeats - 1) + last_len - 9 + 24);
  endfunction

  task automatic send_frame(input logic [LW-1:0] tok, input int n, input int ll, input bit err);
    beat_t b;
    exp_t  e;
    tok_q.push_back(tok);
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = (i == n - 1) ? KW'((1 << ll) - 1) : '1;
      b.last = (i == n - 1);
      beat_q.push_back(b);
      e.b = b;
      e.user = tok;
      exp_q.push_back(e);
    end
    exp_err_q.push_back(CHECK_EN && err);
  endtask

  task automatic flush();
    tok_q.delete();
    beat_q.delete();
    exp_q.delete();
    exp_err_q.delete();
    tok_hs = 1'b0;
    beat_hs = 1'b0;
    first_of_frame = 1'b1;
    err_due = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("frame_timeout", 128'(frames_done >= target), 128'(1));
    if (frames_done < target) begin
      flush();
      frames_done = target;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("rst_outputs", {125'(0), tok_ready, s_ready, m_valid}, 128'(0));
    flush();
    cnt_exp = 0;
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b1;
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      cyc++;
      if (err_due) begin
        check("length_error_pulse", 128'(length_error), 128'(err_exp));
        check("error_count", 128'(error_count), 128'(cnt_exp));
        err_due = 1'b0;
      end else if (length_error !== 1'b0) begin
        check("length_error_spurious", 128'(length_error), 128'(0));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 128'(1), 128'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("beat", 128'({m_data, m_keep, m_last, m_user}), 128'(e));
        end
        if (first_of_frame) frame_start_cyc = cyc;
        first_of_frame = m_last;
        if (m_last) begin
          err_exp = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : 1'b0;
          if (err_exp && cnt_exp != 3) cnt_exp++;
          err_due = 1'b1;
          frames_done++;
        end
      end
      tok_hs = tok_valid && tok_ready;
      if (tok_hs) tok_hs_cyc = cyc;
      beat_hs = s_valid && s_ready;
    end
  end

  // Driver: update inputs just after the active edge.
  always @(posedge clk) begin
    #1;
    if (tok_hs && tok_q.size() > 0) void'(tok_q.pop_front());
    if (beat_hs && beat_q.size() > 0) void'(beat_q.pop_front());
    tok_hs = 1'b0;
    beat_hs = 1'b0;
    tok_valid = (tok_q.size() > 0) && !tok_hold;
    tok_data = (tok_q.size() > 0) ? tok_q[0] : '0;
    s_valid = (beat_q.size() > 0);
    s_data = (beat_q.size() > 0) ? beat_q[0].data : '0;
    s_keep = (beat_q.size() > 0) ? beat_q[0].keep : '0;
    s_last = (beat_q.size() > 0) ? beat_q[0].last : 1'b0;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      default: m_ready = 1'($urandom);
    endcase
  end

  initial begin
    vec_t vecs[6];
    int   stall_bad;
    vecs[0] = '{token: 88,   nbeats: 10,  last_len: 1, mode: 0, err: 1'b0};
    vecs[1] = '{token: 90,   nbeats: 10,  last_len: 1, mode: 0, err: 1'b1};
    vecs[2] = '{token: 1542, nbeats: 191, last_len: 7, mode: 1, err: 1'b0};
    vecs[3] = '{token: 31,   nbeats: 2,   last_len: 8, mode: 2, err: 1'b0};
    vecs[4] = '{token: 16,   nbeats: 1,   last_len: 1, mode: 0, err: 1'b0};
    vecs[5] = '{token: 0,    nbeats: 3,   last_len: 4, mode: 2, err: 1'b1};

    #1;
    check("reset_state", {124'(0), tok_ready, s_ready, m_valid, length_error}, 128'(0));
    check("reset_count", 128'(error_count), 128'(0));
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b1;
    @(negedge clk);
    check("idle_token_ready", 128'({tok_ready, s_ready}), 128'(2'b10));

    for (int i = 0; i < 6; i++) begin
      ready_mode = vecs[i].mode;
      send_frame(LW'(vecs[i].token), vecs[i].nbeats, vecs[i].last_len, vecs[i].err);
      wait_frames(frames_done + 1, 2000);
      if (i == 1) begin
        @(negedge clk);
        check("count_after_mismatch", 128'(error_count), CHECK_EN ? 128'(1) : 128'(0));
      end
    end

    // Data ahead of its token must stall, then start one cycle after the token handshake.
    ready_mode = 0;
    tok_hold = 1'b1;
    send_frame(LW'(88), 10, 1, 1'b0);
    stall_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(s_valid && !s_ready)) stall_bad++;
    end
    check("data_stalled_without_token", 128'(stall_bad), 128'(0));
    tok_hold = 1'b0;
    wait_frames(frames_done + 1, 200);
    check("start_after_token", 128'(frame_start_cyc - tok_hs_cyc), 128'(1));

    // Reset mid-frame, then a clean frame.
    send_frame(LW'(88), 10, 1, 1'b0);
    repeat (5) @(posedge clk);
    do_reset();
    check("count_after_reset", 128'(error_count), 128'(0));
    send_frame(LW'(88), 10, 1, 1'b0);
    wait_frames(frames_done + 1, 200);
    @(negedge clk);
    check("clean_after_reset", 128'({length_error, error_count}), 128'(0));

    // Saturation with a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      send_frame(LW'(90 + i), 10, 1, 1'b1);
      wait_frames(frames_done + 1, 200);
    end
    @(negedge clk);
    check("count_saturated", 128'(error_count), CHECK_EN ? 128'(3) : 128'(0));
    do_reset();

    // Random frames against the arithmetic model.
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int            n;
      int            ll;
      logic [LW-1:0] good;
      logic [LW-1:0] tok;
      n = 1 + int'($urandom_range(0, 11));
      ll = 1 + int'($urandom_range(0, 7));
      good = l1_len(n, ll);
      tok = ($urandom_range(0, 3) == 0) ? LW'($urandom) : good;
      send_frame(tok, n, ll, tok != good);
    end
    wait_frames(frames_done + 40, 5000);
    check("queues_drained", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_length_pairer.md
Name: frame_length_pairer

Overview:
- Consumer end of the frame-length side channel.
- Takes one frame-length token and the matching Ethernet frame ([Frame]/([Timestamp])) from two AXI4-Stream inputs, typically after independent FIFOs.
- Forwards the frame with its length on m_axis_tuser for every beat.
- Recomputes the L1 length from the data beats and flags any token/frame mismatch, so TSN shapers downstream get a length that has been checked against the data.

Parameters:
- C_AXIS_TDATA_WIDTH, 8, data bus width in bits (multiple of 8)
- C_AXIS_TKEEP_WIDTH, C_AXIS_TDATA_WIDTH/8, byte-enable width
- FRAME_LENGTH_WIDTH, 16, width of length token and of tuser
- ENABLE_TIMESTAMP_FOOTER, 1, frame carries a timestamp footer that is excluded from the length
- TIMESTAMP_WIDTH, 72, footer width in bits (multiple of 8)
- L1_LENGTH_OFFSET, 24, bytes added to the L2 length (FCS + preamble + IPG)
- ERROR_COUNT_WIDTH, 16, width of the mismatch counter

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- s_axis_frame_length_tdata  in  FRAME_LENGTH_WIDTH  length token
- s_axis_frame_length_tvalid  in  1  token valid
- s_axis_frame_length_tready  out  1  token ready
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  frame data
- s_axis_tkeep  in  C_AXIS_TKEEP_WIDTH  byte enables
- s_axis_tvalid  in  1  data valid
- s_axis_tready  out  1  data ready
- s_axis_tlast  in  1  last beat of frame
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  forwarded data
- m_axis_tkeep  out  C_AXIS_TKEEP_WIDTH  forwarded keep
- m_axis_tuser  out  FRAME_LENGTH_WIDTH  paired length, constant across the frame
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  forwarded tlast
- length_error  out  1  one-cycle pulse on a mismatch
- error_count  out  ERROR_COUNT_WIDTH  saturating mismatch count

Behaviour:
- Reset (asynchronous, active-low, rstn):
  - state=IDLE, length_reg=0, byte_counter=L1_LENGTH_OFFSET, length_error=0, error_count=0.
  - All tready/tvalid outputs deassert as soon as rstn is low.
- TIMESTAMP_BYTES = TIMESTAMP_WIDTH/8 if ENABLE_TIMESTAMP_FOOTER is set, else 0.
- num_bytes (combinational) = index of the highest set s_axis_tkeep bit + 1; 0 if no bit is set.
- State IDLE:
  - s_axis_frame_length_tready=1, s_axis_tready=0, m_axis_tvalid=0.
  - On token handshake: length_reg<=tdata, byte_counter<=L1_LENGTH_OFFSET, go to FORWARD.
- State FORWARD:
  - s_axis_frame_length_tready=0.
  - m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready.
  - m_axis_tdata, m_axis_tkeep and m_axis_tlast pass through combinationally (zero latency); m_axis_tuser=length_reg.
  - Non-last handshake: byte_counter += C_AXIS_TKEEP_WIDTH.
  - Last handshake: computed = byte_counter + num_bytes - TIMESTAMP_BYTES; compare with length_reg, then go to IDLE.
- All arithmetic is modulo 2^FRAME_LENGTH_WIDTH; there is no overflow detection.
- Mismatch: length_error pulses high for exactly one cycle, the cycle after the last handshake. error_count increments at the same time and saturates at all-ones.
- The frame is always forwarded whole; it is never dropped or truncated.
- Token valid together with data valid in IDLE: the token is taken first and data waits one cycle, so there is a one-cycle bubble per frame.
- Data arriving before its token is stalled (s_axis_tready=0) for as long as needed.
- m_axis_tready low in FORWARD: the counter holds and no beat is lost.
- Reset mid-frame: the partial frame is abandoned and the block returns to IDLE; the upstream sources are cleared by the same reset.

Optional Feature:
- Macro FRAME_LENGTH_PAIRER_CHECK_EN.
- Defined: byte counter, comparison, length_error and error_count are implemented as described above.
- Undefined: no counter or comparator is built; length_error=0 and error_count=0 constantly. Pairing, forwarding and tuser are unchanged.

Test Plan:
- Default test parameters: C_AXIS_TDATA_WIDTH=64, footer 72 bits (9 bytes), offset 24.
- Matched length: token 88, then 9 full beats plus a last beat with tkeep=0x01 (73 bytes) -> tuser=88 on all 10 beats, length_error never high, error_count=0.
- Mismatched length: the same frame with token 90 -> frame forwarded intact; length_error high for exactly 1 cycle after tlast; error_count=1.
- Data before token: frame valid for 20 cycles with no token -> s_axis_tready=0 throughout. Token 88 arrives -> frame starts the cycle after the token handshake.
- Backpressure: m_axis_tready toggled 1/0 every cycle over a 1518-byte frame plus footer, token 1542 -> no beat lost or duplicated, no error.
- Saturation and reset: ERROR_COUNT_WIDTH=2 with 5 mismatched frames -> error_count stops at 3. Assert rstn low mid-frame -> outputs zero immediately; the next token/frame pair passes cleanly.
